// File: rtl/neuron_pkg.sv
// neuron_pkg: FSM state type, activation names, accumulator width helper and
// the saturating add / clamp arithmetic shared by the neuron_lanes slice.
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_ACC,
        ST_DRAIN,
        ST_BIAS,
        ST_ACT,
        ST_OUT
    } state_e;

    localparam string ACT_RELU = "relu";
    localparam string ACT_NONE = "none";

    // Wide enough for any ACC_W plus adder-tree growth used in practice.
    localparam int unsigned CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic int unsigned acc_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic calc_t clamp_w(input calc_t a, input int unsigned w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int unsigned w);
        return clamp_w(a + b, w);
    endfunction

endpackage

// File: rtl/neuron_lanes_if.sv
// neuron_lanes_if: layer load bus, input beat stream and result stream of one neuron.
interface neuron_lanes_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4
);
    logic [31:0]             cfg_layer;
    logic [31:0]             cfg_neuron;
    logic                    w_valid;
    logic [DATA_W-1:0]       w_data;
    logic                    b_valid;
    logic [DATA_W-1:0]       b_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    w_loaded;
    logic                    err_load;

    modport slave (
        input  cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, w_loaded, err_load
    );

    modport master (
        output cfg_layer, cfg_neuron, w_valid, w_data, b_valid, b_data,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, w_loaded, err_load
    );
endinterface

// File: rtl/neuron_wbank.sv
// neuron_wbank: BEATS x (LANES*DATA_W) weight RAM, per-lane write enable,
// synchronous read. Contents are deliberately not reset.
module neuron_wbank
    import neuron_pkg::*;
#(
    parameter int unsigned BEATS  = 196,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                          clk,
    input  logic [LANES-1:0]              we_i,
    input  logic [addr_w(BEATS)-1:0]      waddr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          re_i,
    input  logic [addr_w(BEATS)-1:0]      raddr_i,
    output logic [LANES*DATA_W-1:0]       rdata_o
);

    logic [LANES*DATA_W-1:0] mem_q [BEATS];
    logic [LANES*DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we_i[l]) mem_q[waddr_i][l*DATA_W +: DATA_W] <= wdata_i;
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_lanes.sv
// neuron_lanes: LANES-wide MAC neuron with saturating accumulator, bias and ReLU/none.
// Optional NEURON_ROUND_EN: round-half-up on each product instead of truncation.
module neuron_lanes
    import neuron_pkg::*;
#(
    parameter int unsigned LAYER_NO     = 0,
    parameter int unsigned NEURON_NO    = 0,
    parameter int unsigned NUM_WEIGHT   = 784,
    parameter int unsigned LANES        = 4,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned WEIGHT_INT_W = 1,
    parameter string       ACT          = ACT_RELU
) (
    input logic           clk,
    input logic           rst_n,
    neuron_lanes_if.slave bus
);

    localparam int unsigned BEATS  = NUM_WEIGHT / LANES;
    localparam int unsigned AW     = addr_w(BEATS);
    localparam int unsigned LW     = addr_w(LANES);
    localparam int unsigned FRAC_W = DATA_W - WEIGHT_INT_W;
    localparam int unsigned ACC_W  = acc_w(DATA_W);
    localparam int unsigned PW     = 2 * DATA_W;
    localparam int unsigned TW     = ACC_W + $clog2(LANES);
    localparam bit          RELU   = (ACT == ACT_RELU);

    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

`ifdef NEURON_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_W - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    if ((NUM_WEIGHT % LANES) != 0 || NUM_WEIGHT == 0) begin : g_bad_weights
        $error("neuron_lanes: NUM_WEIGHT must be a non-zero multiple of LANES");
    end
    if (ACT != ACT_RELU && ACT != ACT_NONE) begin : g_bad_act
        $error("neuron_lanes: ACT must be \"relu\" or \"none\"");
    end

    state_e                  state_q, state_d;
    logic [AW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [1:0]              drain_cnt_q, drain_cnt_d;
    logic [AW-1:0]           wword_q;
    logic [LW-1:0]           wlane_q;
    logic                    w_loaded_q, err_load_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] bias_q;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic                    v0_q, v1_q, v2_q;
    logic [LANES*DATA_W-1:0] in_q;
    logic [LANES*DATA_W-1:0] rd_data;
    logic signed [PW-1:0]    prod_d [LANES];
    logic signed [PW-1:0]    prod_q [LANES];
    logic signed [TW-1:0]    tree_d, tree_q;
    logic [LANES-1:0]        bank_we;

    logic in_ready, accept, out_hs, sel, load_win, w_ok, b_ok, drop;

    assign in_ready = (state_q == ST_ACC);
    assign accept   = bus.in_valid && in_ready;
    assign out_hs   = (state_q == ST_OUT) && bus.out_ready;
    assign sel      = (bus.cfg_layer == LAYER_NO) && (bus.cfg_neuron == NEURON_NO);
    assign load_win = (state_q == ST_ACC) && (beat_cnt_q == '0);
    assign w_ok     = sel && bus.w_valid && load_win;
    assign b_ok     = sel && bus.b_valid && load_win;
    assign drop     = sel && (bus.w_valid || bus.b_valid) && !load_win;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (beat_cnt_q == LAST_BEAT) state_d = ST_DRAIN;
                    else beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            // Three cycles let the last beat reach acc before the bias is added.
            ST_DRAIN: begin
                if (drain_cnt_q == 2'd2) begin
                    drain_cnt_d = '0;
                    state_d     = ST_BIAS;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_BIAS: state_d = ST_ACT;
            ST_ACT:  state_d = ST_OUT;
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d    = ST_ACC;
                    beat_cnt_d = '0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // ---------------- weight / bias loading ----------------
    always_comb begin
        bank_we = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            bank_we[l] = w_ok && (wlane_q == LW'(l));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wword_q    <= '0;
            wlane_q    <= '0;
            w_loaded_q <= 1'b0;
            err_load_q <= 1'b0;
            bias_q     <= '0;
        end else begin
            if (out_hs) begin
                wword_q <= '0;
                wlane_q <= '0;
            end else if (w_ok) begin
                if (wlane_q == LAST_LANE) begin
                    wlane_q <= '0;
                    if (wword_q == LAST_BEAT) begin
                        wword_q    <= '0;
                        w_loaded_q <= 1'b1;
                    end else begin
                        wword_q <= wword_q + 1'b1;
                    end
                end else begin
                    wlane_q <= wlane_q + 1'b1;
                end
            end
            if (b_ok) bias_q <= ACC_W'($signed(bus.b_data));
            if (drop) err_load_q <= 1'b1;
        end
    end

    neuron_wbank #(
        .BEATS (BEATS),
        .LANES (LANES),
        .DATA_W(DATA_W)
    ) u_wbank (
        .clk    (clk),
        .we_i   (bank_we),
        .waddr_i(wword_q),
        .wdata_i(bus.w_data),
        .re_i   (accept),
        .raddr_i(beat_cnt_q),
        .rdata_o(rd_data)
    );

    // ---------------- datapath pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            v2_q <= v1_q;
        end
    end

    always_comb begin
        prod_d = '{default: '0};
        for (int unsigned l = 0; l < LANES; l++) begin
            prod_d[l] = (PW'($signed(in_q[l*DATA_W +: DATA_W])) *
                         PW'($signed(rd_data[l*DATA_W +: DATA_W])) + RND) >>> FRAC_W;
        end
    end

    always_comb begin
        tree_d = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            tree_d = tree_d + TW'(prod_q[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) in_q <= bus.in_data;
        prod_q <= prod_d;
        tree_q <= tree_d;
    end

    // ---------------- accumulator, bias and activation ----------------
    always_comb begin
        acc_d = acc_q;
        if (out_hs) acc_d = '0;
        else if (state_q == ST_BIAS)
            acc_d = ACC_W'(sat_add(calc_t'(acc_q), calc_t'(bias_q), ACC_W));
        else if (v2_q)
            acc_d = ACC_W'(sat_add(calc_t'(acc_q), calc_t'(tree_q), ACC_W));
    end

    always_comb begin
        out_data_d = DATA_W'(clamp_w(calc_t'(acc_q), DATA_W));
        if (RELU && acc_q[ACC_W-1]) out_data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (state_q == ST_ACT) out_data_q <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.w_loaded  = w_loaded_q;
    assign bus.err_load  = err_load_q;

endmodule

// File: tb/tb_neuron_lanes.sv
// tb_neuron_lanes: directed scoreboard bench driving a "relu" and a "none" neuron in lockstep.
module tb_neuron_lanes;

    localparam int unsigned DW = 16;
    localparam int unsigned LN = 4;
    localparam int unsigned NW = 8;
    localparam logic [31:0] MY_LAYER  = 32'd2;
    localparam logic [31:0] MY_NEURON = 32'd5;
`ifdef NEURON_ROUND_EN
    localparam logic [DW-1:0] ROUND_EXP = 16'h0008;
`else
    localparam logic [DW-1:0] ROUND_EXP = 16'h0000;
`endif

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_lanes_if #(.DATA_W(DW), .LANES(LN)) bus ();
    neuron_lanes_if #(.DATA_W(DW), .LANES(LN)) bus_n ();

    assign bus_n.cfg_layer  = bus.cfg_layer;
    assign bus_n.cfg_neuron = bus.cfg_neuron;
    assign bus_n.w_valid    = bus.w_valid;
    assign bus_n.w_data     = bus.w_data;
    assign bus_n.b_valid    = bus.b_valid;
    assign bus_n.b_data     = bus.b_data;
    assign bus_n.in_valid   = bus.in_valid;
    assign bus_n.in_data    = bus.in_data;
    assign bus_n.out_ready  = bus.out_ready;

    neuron_lanes #(
        .LAYER_NO(2), .NEURON_NO(5), .NUM_WEIGHT(NW), .LANES(LN),
        .DATA_W(DW), .WEIGHT_INT_W(1), .ACT("relu")
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    neuron_lanes #(
        .LAYER_NO(2), .NEURON_NO(5), .NUM_WEIGHT(NW), .LANES(LN),
        .DATA_W(DW), .WEIGHT_INT_W(1), .ACT("none")
    ) u_dut_none (
        .clk(clk), .rst_n(rst_n), .bus(bus_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int k = 0; k < NW; k++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = w;
            tick();
        end
        bus.w_valid = 1'b0;
        bus.b_valid = 1'b1;
        bus.b_data  = b;
        tick();
        bus.b_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] x);
        int n = 0;
        bus.in_data  = {LN{x}};
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("beat_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit chk_lat, output exp_t e);
        int n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("out_valid_none", 32'(bus_n.out_valid), 32'd1);
        if (chk_lat) check("latency", 32'(n), 32'd5);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
            e.r = '0;
            e.n = '0;
        end else begin
            e = sb.pop_front();
            check("out_data_relu", 32'(bus.out_data), 32'(e.r));
            check("out_data_none", 32'(bus_n.out_data), 32'(e.n));
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_after_hs", 32'(bus.out_valid), 32'd0);
        check("ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input logic [DW-1:0] x, input logic [DW-1:0] er,
                       input logic [DW-1:0] en, input int gap);
        exp_t e;
        sb.push_back('{r: er, n: en});
        send_beat(x);
        repeat (gap) tick();
        send_beat(x);
        wait_out(1'b1, e);
        handshake();
    endtask

    initial begin
        exp_t e;
        bit   seen;
        bus.cfg_layer  = MY_LAYER;
        bus.cfg_neuron = MY_NEURON;
        bus.w_valid    = 1'b0;
        bus.w_data     = '0;
        bus.b_valid    = 1'b0;
        bus.b_data     = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_data_none", 32'(bus_n.out_data), 32'd0);
        check("rst_w_loaded", 32'(bus.w_loaded), 32'd0);
        check("rst_err_load", 32'(bus.err_load), 32'd0);

        // basic sum: 8 * 0.0625 + 0.125 = 0.625
        load(16'h2000, 16'h1000);
        check("w_loaded", 32'(bus.w_loaded), 32'd1);
        check("err_after_load", 32'(bus.err_load), 32'd0);
        run(16'h2000, 16'h5000, 16'h5000, 0);

        // positive saturation, with an in_valid gap
        load(16'h4000, 16'h0000);
        run(16'h4000, 16'h7FFF, 16'h7FFF, 2);

        // negative saturation
        load(16'h8000, 16'h8000);
        run(16'h7FFF, 16'h0000, 16'h8000, 0);

        // activation
        load(16'hE000, 16'h1000);
        run(16'h2000, 16'h0000, 16'hD000, 1);

        // rounding
        load(16'h4000, 16'h0000);
        run(16'h0001, ROUND_EXP, ROUND_EXP, 0);

        // backpressure
        load(16'h2000, 16'h1000);
        sb.push_back('{r: 16'h5000, n: 16'h5000});
        send_beat(16'h2000);
        send_beat(16'h2000);
        wait_out(1'b1, e);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'(e.r));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        handshake();
        run(16'h2000, 16'h5000, 16'h5000, 0);

        // unselected writes are ignored without error
        bus.cfg_neuron = 32'd4;
        load(16'h7FFF, 16'h7FFF);
        bus.cfg_neuron = MY_NEURON;
        check("unsel_no_err", 32'(bus.err_load), 32'd0);

        // selected write after the first beat is dropped
        sb.push_back('{r: 16'h5000, n: 16'h5000});
        send_beat(16'h2000);
        bus.w_valid = 1'b1;
        bus.w_data  = 16'h7FFF;
        tick();
        bus.w_valid = 1'b0;
        check("err_load", 32'(bus.err_load), 32'd1);
        check("err_load_none", 32'(bus_n.err_load), 32'd1);
        send_beat(16'h2000);
        wait_out(1'b1, e);
        handshake();
        check("w_loaded_kept", 32'(bus.w_loaded), 32'd1);

        // asynchronous reset mid-stream
        send_beat(16'h2000);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid || bus_n.out_valid) seen = 1'b1;
        end
        check("no_out_after_rst", 32'(seen), 32'd0);
        check("rst2_w_loaded", 32'(bus.w_loaded), 32'd0);
        check("rst2_err_load", 32'(bus.err_load), 32'd0);
        check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst2_out_data", 32'(bus.out_data), 32'd0);

        load(16'h2000, 16'h1000);
        check("reload_w_loaded", 32'(bus.w_loaded), 32'd1);
        run(16'h2000, 16'h5000, 16'h5000, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
